clk_freq_divider: RTL and testbench



---
 rtl/clk_freq_divider.sv | 89 ++++++++
 tb/tb_clk_freq_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clk_freq_divider.sv
// -----------------------------------------------------------------------------
// clk_freq_divider
//
// Divides a fast free-running source clock down to a slow 50%-duty clock by
// counting source edges and toggling a registered output every HALF_PERIOD
// edges. The default setting produces 10 Hz from 50 MHz and paces the chess
// board layout logic so that key presses advance at a human rate. A one-cycle
// tick in the source domain marks every generated rising edge, so logic that
// stays on InClock can follow the slow clock without crossing domains.
//
// Parameters:
//   INPUT_FREQUENCY  - frequency of InClock in Hz
//   OUTPUT_FREQUENCY - target frequency of OutClock in Hz
//
// Ports:
//   InClock   in   1  fast source clock, all state updates on its rising edge
//   resetApp  in   1  asynchronous, active-high reset
//   OutClock  out  1  divided clock, driven straight from a flop
//   OutTick   out  1  one-InClock-cycle pulse on each OutClock 0->1 transition
// -----------------------------------------------------------------------------
module clk_freq_divider #(
    parameter int INPUT_FREQUENCY  = 50_000_000,
    parameter int OUTPUT_FREQUENCY = 10
) (
    input  logic InClock,
    input  logic resetApp,
    output logic OutClock,
    output logic OutTick
);

    // The guard on OUTPUT_FREQUENCY keeps the division legal while the
    // parameter check below reports the real problem.
    localparam int HALF_PERIOD = (OUTPUT_FREQUENCY > 0)
                               ? INPUT_FREQUENCY / (2 * OUTPUT_FREQUENCY)
                               : 0;
    localparam int CNT_WIDTH   = ($clog2(HALF_PERIOD) > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HALF_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Reject any configuration that cannot produce at least one source edge
    // per output phase; there is deliberately no fallback divide ratio.
    if (INPUT_FREQUENCY <= 0 || OUTPUT_FREQUENCY <= 0 || HALF_PERIOD < 1) begin : gBadParams
        $error("clk_freq_divider: HALF_PERIOD must be >= 1 (INPUT_FREQUENCY=%0d, OUTPUT_FREQUENCY=%0d)",
               INPUT_FREQUENCY, OUTPUT_FREQUENCY);
    end

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cntNext;
    logic                 cntWrap;
    logic                 outClockNext;
    logic                 outTickNext;

    // Next-state logic. The counter runs 0..HALF_PERIOD-1; on the wrap edge
    // the output toggles, and the tick fires only when that toggle is a rise.
    // With HALF_PERIOD == 1 the counter is a constant 0 and every edge wraps,
    // which gives a plain divide-by-two.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing branch here would infer a latch.
        cntNext      = cnt + CNT_ONE;
        outClockNext = OutClock;
        outTickNext  = 1'b0;
        cntWrap      = (cnt == CNT_LAST);
        if (cntWrap) begin
            cntNext      = '0;
            outClockNext = ~OutClock;
            outTickNext  = ~OutClock;
        end
    end

    // State register. Reset assertion clears everything at once, including
    // a half-finished phase; counting restarts from zero on the first rising
    // InClock edge that sees resetApp low.
    always_ff @(posedge InClock or posedge resetApp) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (resetApp) begin
            cnt      <= '0;
            OutClock <= 1'b0;
            OutTick  <= 1'b0;
        end else begin
            cnt      <= cntNext;
            OutClock <= outClockNext;
            OutTick  <= outTickNext;
        end
    end

endmodule

// File: tb/tb_clk_freq_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_freq_divider
//
// Drives three divider instances from one source clock and one reset:
//   HALF_PERIOD 5 (100 -> 10), HALF_PERIOD 3 (70 -> 10), HALF_PERIOD 1 (20 -> 10).
// A behavioural model counts counting edges since the last reset release and
// derives the expected outputs arithmetically; a compare process checks every
// instance on every falling InClock edge. Directed literal checks pin rise and
// fall positions, periods, tick placement and the asynchronous reset.
// -----------------------------------------------------------------------------
module tb_clk_freq_divider;

    logic InClock  = 1'b0;
    logic resetApp = 1'b1;

    logic clk5, tick5, clk3, tick3, clk1, tick1;

    int checks = 0;
    int errors = 0;

    always #5 InClock = ~InClock;

    clk_freq_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dut5 (
        .InClock (InClock),
        .resetApp(resetApp),
        .OutClock(clk5),
        .OutTick (tick5)
    );

    clk_freq_divider #(.INPUT_FREQUENCY(70), .OUTPUT_FREQUENCY(10)) dut3 (
        .InClock (InClock),
        .resetApp(resetApp),
        .OutClock(clk3),
        .OutTick (tick3)
    );

    clk_freq_divider #(.INPUT_FREQUENCY(20), .OUTPUT_FREQUENCY(10)) dut1 (
        .InClock (InClock),
        .resetApp(resetApp),
        .OutClock(clk1),
        .OutTick (tick1)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // edges = number of InClock rises seen with resetApp low since the last
    // reset. OutClock has toggled once per completed half period, and a tick
    // marks the exact edge where an odd-numbered half period completes.
    int edges = 0;

    always @(posedge InClock or posedge resetApp) begin
        if (resetApp) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic int expClk(input int k, input int hp);
        return (k / hp) % 2;
    endfunction

    function automatic int expTick(input int k, input int hp);
        return (k > 0 && (k % hp) == 0 && ((k / hp) % 2) == 1) ? 1 : 0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge InClock) begin
        check("model clk5",  int'(clk5),  expClk(edges, 5));
        check("model tick5", int'(tick5), expTick(edges, 5));
        check("model clk3",  int'(clk3),  expClk(edges, 3));
        check("model tick3", int'(tick3), expTick(edges, 3));
        check("model clk1",  int'(clk1),  expClk(edges, 1));
        check("model tick1", int'(tick1), expTick(edges, 1));
    end

    // ---------------- directed stimulus ----------------
    int rise5[$], fall5[$], tickAt5[$], rise3[$], rise1[$];
    logic prev5, prev3, prev1;

    initial begin
        // Reset hold: 20 cycles with resetApp high, outputs pinned at zero.
        repeat (20) @(negedge InClock);
        check("reset hold clk5",  int'(clk5),  0);
        check("reset hold tick5", int'(tick5), 0);
        check("reset hold clk1",  int'(clk1),  0);

        // Release on a falling edge; edge 1 is the next rising edge.
        resetApp = 1'b0;
        prev5 = 1'b0; prev3 = 1'b0; prev1 = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge InClock);
            #1;
            if (clk5 && !prev5) rise5.push_back(e);
            if (!clk5 && prev5) fall5.push_back(e);
            if (tick5)          tickAt5.push_back(e);
            if (clk3 && !prev3) rise3.push_back(e);
            if (clk1 && !prev1) rise1.push_back(e);
            prev5 = clk5; prev3 = clk3; prev1 = clk1;
        end

        // HALF_PERIOD 5: rises 5,15,25..95, falls 10,20..100.
        check("hp5 rise count", rise5.size(), 10);
        check("hp5 fall count", fall5.size(), 10);
        if (rise5.size() >= 3 && fall5.size() >= 2) begin
            check("hp5 rise0",  rise5[0], 5);
            check("hp5 rise1",  rise5[1], 15);
            check("hp5 rise2",  rise5[2], 25);
            check("hp5 fall0",  fall5[0], 10);
            check("hp5 fall1",  fall5[1], 20);
            check("hp5 period", rise5[1] - rise5[0], 10);
            check("hp5 high",   fall5[0] - rise5[0], 5);
            check("hp5 low",    rise5[1] - fall5[0], 5);
        end
        // Ticks: one cycle each, only at rises, never at falls.
        check("hp5 tick count", tickAt5.size(), 10);
        for (int i = 0; i < tickAt5.size() && i < 10; i++)
            check("hp5 tick pos", tickAt5[i], 5 + 10 * i);

        // HALF_PERIOD 3: rises 3,9..99, period 6.
        check("hp3 rise count", rise3.size(), 17);
        if (rise3.size() >= 2) begin
            check("hp3 rise0",  rise3[0], 3);
            check("hp3 period", rise3[1] - rise3[0], 6);
        end

        // HALF_PERIOD 1: rises on every odd edge.
        check("hp1 rise count", rise1.size(), 50);
        if (rise1.size() >= 2) begin
            check("hp1 rise0",  rise1[0], 1);
            check("hp1 period", rise1[1] - rise1[0], 2);
        end

        // Asynchronous reset in the middle of the high phase.
        @(negedge InClock);
        resetApp = 1'b1;
        repeat (2) @(negedge InClock);
        resetApp = 1'b0;
        repeat (7) @(posedge InClock);
        #2;
        check("pre-reset clk5 high", int'(clk5), 1);
        resetApp = 1'b1;          // between edges 7 and 8, no clock edge
        #1;
        check("async clk5",  int'(clk5),  0);
        check("async tick5", int'(tick5), 0);
        check("async clk3",  int'(clk3),  0);
        @(negedge InClock);
        resetApp = 1'b0;
        repeat (4) @(posedge InClock);
        #1;
        check("restart clk5 edge4", int'(clk5), 0);
        @(posedge InClock);
        #1;
        check("restart clk5 edge5",  int'(clk5),  1);
        check("restart tick5 edge5", int'(tick5), 1);
        @(posedge InClock);
        #1;
        check("restart tick5 edge6", int'(tick5), 0);

        repeat (20) @(negedge InClock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
